// File: rtl/gaussian3x3_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : gaussian3x3_stream_if
// Brief    : Input and output pixel stream handshake bundle for the 3x3 blur.
// Revision : 1.0 - initial release
// ============================================================================
interface gaussian3x3_stream_if #(
  parameter int PIXEL_BIT_WIDTH = 12
);
  logic [PIXEL_BIT_WIDTH-1:0] pixel_in_TDATA;
  logic                       pixel_in_TVALID;
  logic                       pixel_in_TREADY;
  logic [PIXEL_BIT_WIDTH-1:0] pixel_out_TDATA;
  logic                       pixel_out_TVALID;
  logic                       pixel_out_TREADY;
  logic                       pixel_out_TLAST;

  // Environment side: feeds pixels in and consumes blurred pixels
  modport master (
    output pixel_in_TDATA,
    output pixel_in_TVALID,
    input  pixel_in_TREADY,
    input  pixel_out_TDATA,
    input  pixel_out_TVALID,
    output pixel_out_TREADY,
    input  pixel_out_TLAST
  );

  modport slave (
    input  pixel_in_TDATA,
    input  pixel_in_TVALID,
    output pixel_in_TREADY,
    output pixel_out_TDATA,
    output pixel_out_TVALID,
    input  pixel_out_TREADY,
    output pixel_out_TLAST
  );
endinterface
`default_nettype wire

// File: rtl/gaussian3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : gaussian3x3_stream
// Brief    : Streaming 3x3 Gaussian blur, two line buffers, valid-region output.
// Revision : 1.0 - initial release
// ============================================================================
module gaussian3x3_stream #(
  parameter int PIXEL_BIT_WIDTH  = 12,
  parameter int IN_ROWS          = 20,
  parameter int IN_COLS          = 20,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10
) (
  input  wire logic             clk,
  input  wire logic             reset,
  gaussian3x3_stream_if.slave   pix
);

  localparam int c_sum_w  = PIXEL_BIT_WIDTH + 4;
  localparam int c_lb_aw  = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;

  localparam logic [IMG_COL_BITWIDTH-1:0] c_last_col = IMG_COL_BITWIDTH'(IN_COLS - 1);
  localparam logic [IMG_ROW_BITWIDTH-1:0] c_last_row = IMG_ROW_BITWIDTH'(IN_ROWS - 1);
  localparam logic [IMG_COL_BITWIDTH-1:0] c_two_col  = IMG_COL_BITWIDTH'(2);
  localparam logic [IMG_ROW_BITWIDTH-1:0] c_two_row  = IMG_ROW_BITWIDTH'(2);
  localparam logic [IMG_COL_BITWIDTH-1:0] c_one_col  = IMG_COL_BITWIDTH'(1);
  localparam logic [IMG_ROW_BITWIDTH-1:0] c_one_row  = IMG_ROW_BITWIDTH'(1);
  localparam logic [c_sum_w-1:0]          c_round    = c_sum_w'(8);

  typedef logic [PIXEL_BIT_WIDTH-1:0] pix_t;

  logic [IMG_COL_BITWIDTH-1:0] r_x;
  logic [IMG_ROW_BITWIDTH-1:0] r_y;

  pix_t r_lb0 [IN_COLS];
  pix_t r_lb1 [IN_COLS];
  // Window keeps only the two older columns; the newest column is formed from
  // the line buffer read-out and the incoming pixel.
  pix_t r_win_l [3];
  pix_t r_win_m [3];

  logic r_out_valid;
  logic r_out_last;
  pix_t r_out_data;

  logic               w_accept;
  logic               w_in_ready;
  logic               w_last_col;
  logic               w_last_row;
  logic               w_out_en;
  logic [c_lb_aw-1:0] w_lb_idx;
  pix_t               w_top;
  pix_t               w_mid;
  pix_t               w_bot;
  logic [c_sum_w-1:0] w_sum;
  logic [c_sum_w-1:0] w_rounded;
  pix_t               w_result;

  assign w_in_ready = ~r_out_valid | pix.pixel_out_TREADY;
  assign w_accept   = pix.pixel_in_TVALID & w_in_ready;
  assign w_last_col = (r_x == c_last_col);
  assign w_last_row = (r_y == c_last_row);
  assign w_out_en   = (r_y >= c_two_row) && (r_x >= c_two_col);

  assign w_lb_idx = r_x[c_lb_aw-1:0];
  assign w_top    = r_lb1[w_lb_idx];
  assign w_mid    = r_lb0[w_lb_idx];
  assign w_bot    = pix.pixel_in_TDATA;

  assign w_sum = c_sum_w'(r_win_l[0])         + (c_sum_w'(r_win_m[0]) << 1) + c_sum_w'(w_top)
               + (c_sum_w'(r_win_l[1]) << 1)  + (c_sum_w'(r_win_m[1]) << 2) + (c_sum_w'(w_mid) << 1)
               + c_sum_w'(r_win_l[2])         + (c_sum_w'(r_win_m[2]) << 1) + c_sum_w'(w_bot);

  // Max sum is 16*(2^W-1); adding 8 still fits in W+4 bits
  assign w_rounded = w_sum + c_round;
  assign w_result  = pix_t'(w_rounded >> 4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_x <= '0;
        r_y <= w_last_row ? '0 : (r_y + c_one_row);
      end else begin
        r_x <= r_x + c_one_col;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= w_out_en;
      r_out_last  <= w_last_row & w_last_col;
      r_out_data  <= w_result;
    end else if (pix.pixel_out_TREADY) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[w_lb_idx] <= w_mid;
      r_lb0[w_lb_idx] <= w_bot;
      r_win_l         <= r_win_m;
      r_win_m[0]      <= w_top;
      r_win_m[1]      <= w_mid;
      r_win_m[2]      <= w_bot;
    end
  end

  assign pix.pixel_in_TREADY  = w_in_ready;
  assign pix.pixel_out_TVALID = r_out_valid;
  assign pix.pixel_out_TDATA  = r_out_data;
  assign pix.pixel_out_TLAST  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_gaussian3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_gaussian3x3_stream
// Brief    : Self-checking bench for gaussian3x3_stream against a frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gaussian3x3_stream;

  localparam int ROWS = 20;
  localparam int COLS = 20;
  localparam int W    = 12;
  localparam int NOUT = (ROWS - 2) * (COLS - 2);

  logic clk;
  logic reset;

  gaussian3x3_stream_if #(.PIXEL_BIT_WIDTH(W)) bus ();

  gaussian3x3_stream #(
    .PIXEL_BIT_WIDTH  (W),
    .IN_ROWS          (ROWS),
    .IN_COLS          (COLS),
    .IMG_ROW_BITWIDTH (10),
    .IMG_COL_BITWIDTH (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pix   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int unsigned img [ROWS][COLS];
  int unsigned in_q[$];
  int unsigned exp_d[$];
  bit          exp_l[$];
  int unsigned got_d[$];
  bit          got_l[$];
  int          proto_viol;
  int          last_accept_iter;
  bit          timed_out;

  task automatic clear_queues();
    in_q.delete();
    exp_d.delete();
    exp_l.delete();
  endtask

  // Reference: plain 2D convolution over the interior of the frame
  task automatic model_add_frame();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        in_q.push_back(img[r][c]);
    for (int r = 1; r < ROWS - 1; r++) begin
      for (int c = 1; c < COLS - 1; c++) begin
        int unsigned s;
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * img[r+dr][c+dc];
        exp_d.push_back((s + 8) / 16);
        exp_l.push_back((r == ROWS - 2) && (c == COLS - 2));
      end
    end
  endtask

  task automatic fill_const(input int unsigned v);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        img[r][c] = v;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        img[r][c] = c + 20 * r;
  endtask

  task automatic fill_random();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        img[r][c] = $urandom_range(4095);
  endtask

  // Drives in_q with random valid/ready gaps, records every output handshake
  // and counts protocol violations seen along the way.
  task automatic run_stream(input int vprob, input int rprob);
    int         idx;
    int         iter;
    bit         held;
    logic [W-1:0] held_d;
    logic       held_l;
    bit         rdy;
    bit         vld;
    idx = 0; iter = 0; held = 0; held_d = '0; held_l = 1'b0;
    got_d.delete(); got_l.delete();
    proto_viol = 0; timed_out = 0; last_accept_iter = -1;
    while (idx < in_q.size() || got_d.size() < exp_d.size()) begin
      @(negedge clk);
      if (iter >= 20000) begin
        timed_out = 1;
        break;
      end
      if (held && (bus.pixel_out_TVALID !== 1'b1 || bus.pixel_out_TDATA !== held_d ||
                   bus.pixel_out_TLAST !== held_l))
        proto_viol++;
      rdy = ($urandom_range(99) < rprob);
      vld = (idx < in_q.size()) && ($urandom_range(99) < vprob);
      bus.pixel_out_TREADY = rdy;
      bus.pixel_in_TVALID  = vld;
      bus.pixel_in_TDATA   = vld ? W'(in_q[idx]) : W'($urandom_range(4095));
      #1;
      if (bus.pixel_in_TREADY !== (!bus.pixel_out_TVALID || rdy))
        proto_viol++;
      if (bus.pixel_out_TVALID === 1'b1 && rdy) begin
        got_d.push_back(bus.pixel_out_TDATA);
        got_l.push_back(bus.pixel_out_TLAST);
      end
      held   = (bus.pixel_out_TVALID === 1'b1) && !rdy;
      held_d = bus.pixel_out_TDATA;
      held_l = bus.pixel_out_TLAST;
      if (vld && bus.pixel_in_TREADY === 1'b1) begin
        idx++;
        last_accept_iter = iter;
      end
      iter++;
    end
    @(negedge clk);
    bus.pixel_in_TVALID  = 1'b0;
    bus.pixel_out_TREADY = 1'b1;
  endtask

  task automatic test_reset();
    bus.pixel_in_TVALID  = 1'b0;
    bus.pixel_in_TDATA   = '0;
    bus.pixel_out_TREADY = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.pixel_out_TVALID !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b required 0", bus.pixel_out_TVALID); end
    checks++; if (bus.pixel_out_TDATA !== '0) begin errors++; $display("FAIL reset_tdata: got %0d required 0", bus.pixel_out_TDATA); end
    checks++; if (bus.pixel_out_TLAST !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b required 0", bus.pixel_out_TLAST); end
    checks++; if (bus.pixel_in_TREADY !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b required 1", bus.pixel_in_TREADY); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_constant();
    clear_queues(); fill_const(100); model_add_frame();
    run_stream(100, 100);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL const_timeout: got %0d required 0", timed_out); end
    checks++; if (got_d.size() !== NOUT) begin errors++; $display("FAIL const_count: got %0d required %0d", got_d.size(), NOUT); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== 100 || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL const_out[%0d]: got data=%0d last=%0d required data=100 last=%0d", i, got_d[i], got_l[i], exp_l[i]);
      end
    end
    checks++; if (last_accept_iter !== ROWS * COLS - 1) begin errors++; $display("FAIL const_no_gaps: last accept cycle %0d required %0d", last_accept_iter, ROWS * COLS - 1); end
  endtask

  task automatic test_impulse();
    clear_queues(); fill_const(0); img[5][5] = 160; model_add_frame();
    run_stream(100, 100);
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL impulse_count: got %0d required %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL impulse_out[%0d]: got data=%0d last=%0d required data=%0d last=%0d", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++; if (got_d[4*18+4] !== 40) begin errors++; $display("FAIL impulse_centre: got %0d required 40", got_d[4*18+4]); end
    checks++; if (got_d[3*18+4] !== 20) begin errors++; $display("FAIL impulse_edge: got %0d required 20", got_d[3*18+4]); end
    checks++; if (got_d[3*18+3] !== 10) begin errors++; $display("FAIL impulse_diag: got %0d required 10", got_d[3*18+3]); end
    checks++; if (got_d[6*18+6] !== 0) begin errors++; $display("FAIL impulse_far: got %0d required 0", got_d[6*18+6]); end
  endtask

  task automatic test_rounding();
    clear_queues(); fill_const(0); img[5][5] = 8; model_add_frame();
    run_stream(100, 100);
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL round_count: got %0d required %0d", got_d.size(), exp_d.size()); end
    checks++; if (got_d[4*18+4] !== 2) begin errors++; $display("FAIL round_centre: got %0d required 2", got_d[4*18+4]); end
    checks++; if (got_d[4*18+5] !== 1) begin errors++; $display("FAIL round_edge: got %0d required 1", got_d[4*18+5]); end
    checks++; if (got_d[5*18+5] !== 1) begin errors++; $display("FAIL round_diag: got %0d required 1", got_d[5*18+5]); end
  endtask

  task automatic test_max_and_ramp();
    clear_queues(); fill_const(4095); model_add_frame();
    run_stream(100, 100);
    checks++; if (got_d.size() !== NOUT) begin errors++; $display("FAIL max_count: got %0d required %0d", got_d.size(), NOUT); end
    for (int i = 0; i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== 4095) begin errors++; $display("FAIL max_out[%0d]: got %0d required 4095", i, got_d[i]); end
    end
    clear_queues(); fill_ramp(); model_add_frame();
    run_stream(100, 100);
    checks++; if (got_d.size() !== NOUT) begin errors++; $display("FAIL ramp_count: got %0d required %0d", got_d.size(), NOUT); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL ramp_out[%0d]: got %0d required %0d", i, got_d[i], exp_d[i]); end
    end
    checks++; if (got_d[0] !== 21) begin errors++; $display("FAIL ramp_first: got %0d required 21", got_d[0]); end
    checks++; if (got_d[NOUT-1] !== 378) begin errors++; $display("FAIL ramp_last: got %0d required 378", got_d[NOUT-1]); end
  endtask

  task automatic test_backpressure();
    clear_queues(); fill_ramp(); model_add_frame();
    run_stream(70, 60);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %0d required 0", timed_out); end
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL bp_count: got %0d required %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL bp_out[%0d]: got data=%0d last=%0d required data=%0d last=%0d", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++; if (proto_viol !== 0) begin errors++; $display("FAIL bp_protocol: got %0d violations required 0", proto_viol); end
  endtask

  task automatic test_random_bp();
    clear_queues(); fill_random(); model_add_frame();
    run_stream(80, 50);
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL rnd_count: got %0d required %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL rnd_out[%0d]: got data=%0d last=%0d required data=%0d last=%0d", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++; if (proto_viol !== 0) begin errors++; $display("FAIL rnd_protocol: got %0d violations required 0", proto_viol); end
  endtask

  task automatic test_reset_midframe();
    clear_queues();
    for (int i = 0; i < 150; i++) in_q.push_back($urandom_range(4095));
    run_stream(100, 100);
    bus.pixel_out_TREADY = 1'b0;
    #1;
    checks++; if (bus.pixel_out_TVALID !== 1'b1) begin errors++; $display("FAIL midrst_pending: got %b required 1", bus.pixel_out_TVALID); end
    reset = 1'b0;
    #1;
    checks++; if (bus.pixel_out_TVALID !== 1'b0 || bus.pixel_out_TDATA !== '0 || bus.pixel_out_TLAST !== 1'b0) begin
      errors++; $display("FAIL midrst_async: got valid=%b data=%0d last=%b required 0 0 0", bus.pixel_out_TVALID, bus.pixel_out_TDATA, bus.pixel_out_TLAST);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.pixel_out_TREADY = 1'b1;
    clear_queues(); fill_const(50); model_add_frame();
    run_stream(100, 100);
    checks++; if (got_d.size() !== NOUT) begin errors++; $display("FAIL midrst_count: got %0d required %0d", got_d.size(), NOUT); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== 50 || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL midrst_out[%0d]: got data=%0d last=%0d required data=50 last=%0d", i, got_d[i], got_l[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nlast;
    clear_queues();
    fill_random(); model_add_frame();
    fill_random(); model_add_frame();
    run_stream(100, 100);
    checks++; if (got_d.size() !== 2 * NOUT) begin errors++; $display("FAIL b2b_count: got %0d required %0d", got_d.size(), 2 * NOUT); end
    nlast = 0;
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      if (got_l[i]) nlast++;
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL b2b_out[%0d]: got data=%0d last=%0d required data=%0d last=%0d", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++; if (nlast !== 2) begin errors++; $display("FAIL b2b_tlast: got %0d required 2", nlast); end
    checks++; if (last_accept_iter !== 2 * ROWS * COLS - 1) begin errors++; $display("FAIL b2b_no_gaps: last accept cycle %0d required %0d", last_accept_iter, 2 * ROWS * COLS - 1); end
  endtask

  initial begin
    reset = 1'b0;
    bus.pixel_in_TVALID  = 1'b0;
    bus.pixel_in_TDATA   = '0;
    bus.pixel_out_TREADY = 1'b1;
    test_reset();
    test_constant();
    test_impulse();
    test_rounding();
    test_max_and_ramp();
    test_backpressure();
    test_random_bp();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
